// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, taken branch and data-memory wait with timeout.
// Optional performance counters are enabled with `define HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_stall,
  output logic                  exmem_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  mem_err,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
`endif
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // wait_cnt holds the number of stall cycles already completed before the current one.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             memwait_hit;
  logic             ack_hit;
  logic             load_use;

  assign memwait_hit = mem_req & ~mem_ack;
  assign ack_hit     = mem_req & mem_ack;
  assign load_use    = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memwait_hit) begin
            // With a timeout of one cycle the first stall is already the last.
            if (MEM_TIMEOUT <= 1) begin
              state <= ERR;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= CNT_W'(1);
            end
          end
        end
        MEM_WAIT: begin
          if (ack_hit) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= LAST_WAIT) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ERR;
      endcase
    end
  end

  // Mealy outputs: hazards act in the cycle they are observed.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_err     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (memwait_hit) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!ack_hit) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
          end
        end
        default: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
          mem_err     = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ifid_flush | idex_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT = 4); output vector order:
// {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_flush, mem_err}.
module tb_hazard_ctrl;

  localparam logic [7:0] NONE   = 8'b0000_0000;
  localparam logic [7:0] STALL4 = 8'b1111_0010;
  localparam logic [7:0] ERRV   = 8'b1111_0011;
  localparam logic [7:0] LU     = 8'b1100_0100;
  localparam logic [7:0] BR     = 8'b0000_1100;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, ex_branch_taken, mem_req, mem_ack;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [1:0] dbg_state;
  logic [7:0] outs;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  logic [7:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .exmem_stall     (exmem_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .mem_err         (mem_err),
`ifdef HAZARD_CTRL_PERF_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .dbg_state       (dbg_state)
  );

  assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                 ifid_flush, idex_flush, memwb_flush, mem_err};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic memrd, input logic br, input logic req, input logic ack);
    id_rs1          = rs1;
    id_rs2          = rs2;
    ex_rd           = rd;
    ex_memread      = memrd;
    ex_branch_taken = br;
    mem_req         = req;
    mem_ack         = ack;
  endtask

  // One clock cycle: drive just after the edge, sample mid-cycle.
  task automatic cycle(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic memrd, input logic br,
                       input logic req, input logic ack, input logic [7:0] exp);
    @(posedge clk);
    #1;
    drive(rs1, rs2, rd, memrd, br, req, ack);
    exp_q.push_back(exp);
    #3;
    check(tag, {24'd0, outs}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic idle(input string tag);
    cycle(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    check("reset_outs", {24'd0, outs}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    idle("idle");
    // load-use
    cycle("load_use_rs2", 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    idle("load_use_one_cycle");
    cycle("load_use_rs1", 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    cycle("load_use_x0", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    cycle("no_load_match", 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
    cycle("no_reg_match", 5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    // branch beats load-use
    cycle("branch_over_lu", 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR);
    idle("after_branch");
    check("branch_state", {30'd0, dbg_state}, 32'd0);

    // memory wait, ack in the third cycle, branch ignored throughout
    cycle("memwait_c1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL4);
    cycle("memwait_c2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL4);
    check("memwait_state", {30'd0, dbg_state}, 32'd1);
    cycle("memwait_ack", 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, NONE);
    idle("after_ack");
    check("after_ack_state", {30'd0, dbg_state}, 32'd0);

    // ack without request is ignored
    cycle("ack_no_req_run", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE);
    cycle("ack_no_req_w1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("ack_no_req_w2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, STALL4);
    cycle("ack_no_req_w3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NONE);
    idle("ack_no_req_done");

    // timeout: 4 stall cycles, error from cycle 5
    for (int i = 1; i <= 4; i++)
      cycle($sformatf("timeout_stall%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("timeout_err", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERRV);
    cycle("err_ack_ignored", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ERRV);
    cycle("err_inputs_ignored", 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, ERRV);
    check("err_state", {30'd0, dbg_state}, 32'd2);

    // asynchronous reset while in ERR
    #1;
    reset = 1'b1;
    #1;
    check("reset_in_err", {24'd0, outs}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("after_err_reset");
    check("after_err_reset_merr", {31'd0, mem_err}, 32'd0);

    // asynchronous reset while waiting with wait_cnt = 2
    cycle("rst_wait_c1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("rst_wait_c2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_in_wait", {24'd0, outs}, 32'd0);
    check("reset_in_wait_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("after_wait_reset");
    // the wait counter restarted: a fresh timeout still needs 4 stalls
    for (int i = 1; i <= 4; i++)
      cycle($sformatf("retimeout_stall%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("retimeout_err", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERRV);

`ifdef HAZARD_CTRL_PERF_EN
    apply_reset();
    check("perf_reset_stall", perf_stall_cnt, 32'd0);
    check("perf_reset_flush", perf_flush_cnt, 32'd0);
    cycle("perf_w1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("perf_w2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL4);
    cycle("perf_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NONE);
    cycle("perf_branch", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);
    cycle("perf_lu", 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    idle("perf_idle");
    check("perf_stall_cnt", perf_stall_cnt, 32'd3);
    check("perf_flush_cnt", perf_flush_cnt, 32'd2);
`else
    apply_reset();
    idle("final_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
